// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Default 640x480@60 timing constants and total-length helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int   c_h_display = 640;
    localparam int   c_h_front   = 16;
    localparam int   c_h_sync    = 96;
    localparam int   c_h_back    = 48;
    localparam int   c_v_display = 480;
    localparam int   c_v_front   = 10;
    localparam int   c_v_sync    = 2;
    localparam int   c_v_back    = 33;
    localparam logic c_sync_pol  = 1'b0;
    // Counters are 10 bits wide, so neither total may exceed this.
    localparam int   c_max_total = 1024;

    function automatic int calc_total(input int disp, input int front,
                                      input int sync, input int back);
        return disp + front + sync + back;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_if.sv
// ============================================================================
// Module : vga_sync_if
// Brief  : Timing bundle from the sync generator to pixel/object blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface vga_sync_if;

    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_tick;

    modport master (
        output hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_tick
    );

    modport slave (
        input  hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_tick
    );

endinterface

`default_nettype wire

// File: rtl/pixel_tick_div.sv
// ============================================================================
// Module : pixel_tick_div
// Brief  : Divides clk by DIV into a one-clk pixel strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pixel_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic o_p_tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_div_cnt;
    logic               w_wrap;

    generate
        if (DIV < 1) begin : g_div_check
            $error("pixel_tick_div: DIV must be at least 1");
        end
    endgenerate

    assign w_wrap = (r_div_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_div_cnt <= '0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Gated by rstn so the strobe is low for the whole reset, even with DIV=1.
    assign o_p_tick = w_wrap && rstn;

endmodule

`default_nettype wire

// File: rtl/vga_sync.sv
// ============================================================================
// Module : vga_sync
// Brief  : 640x480 VGA timing generator (counters, sync decode, frame tick).
//          VGA_SYNC_PIPE_EN delays hsync/vsync/video_on by one pixel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_sync
    import vga_pkg::*;
#(
    parameter int   DIV       = 4,
    parameter int   H_DISPLAY = c_h_display,
    parameter int   H_FRONT   = c_h_front,
    parameter int   H_SYNC    = c_h_sync,
    parameter int   H_BACK    = c_h_back,
    parameter int   V_DISPLAY = c_v_display,
    parameter int   V_FRONT   = c_v_front,
    parameter int   V_SYNC    = c_v_sync,
    parameter int   V_BACK    = c_v_back,
    parameter logic SYNC_POL  = c_sync_pol
) (
    input  logic        clk,
    input  logic        rstn,
    vga_sync_if.master  vga
);

    localparam int c_h_total = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int c_v_total = calc_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [9:0]  c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0]  c_v_frame  = 10'(V_DISPLAY + 1);
    localparam logic [10:0] c_h_disp   = 11'(H_DISPLAY);
    localparam logic [10:0] c_v_disp   = 11'(V_DISPLAY);
    localparam logic [10:0] c_hs_start = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] c_hs_end   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] c_vs_start = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] c_vs_end   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    generate
        if (c_h_total > c_max_total || c_v_total > c_max_total) begin : g_total_check
            $error("vga_sync: H_TOTAL or V_TOTAL exceeds 1024");
        end
    endgenerate

    logic       w_p_tick;
    logic [9:0] r_x, r_y;
    logic [9:0] w_x_next, w_y_next;
    logic       r_hsync, r_vsync;
    logic       w_hsync_act, w_vsync_act;
    logic       w_video_on;

    pixel_tick_div #(
        .DIV      (DIV)
    ) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .o_p_tick (w_p_tick)
    );

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            if (r_x == c_h_last) begin
                w_x_next = '0;
                w_y_next = (r_y == c_v_last) ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Decoding the next-state position lets sync change on the same edge
    // as the counters it belongs to.
    assign w_hsync_act = ({1'b0, w_x_next} >= c_hs_start) && ({1'b0, w_x_next} < c_hs_end);
    assign w_vsync_act = ({1'b0, w_y_next} >= c_vs_start) && ({1'b0, w_y_next} < c_vs_end);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_hsync <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign w_video_on = ({1'b0, r_x} < c_h_disp) && ({1'b0, r_y} < c_v_disp);

`ifdef VGA_SYNC_PIPE_EN
    logic r_hsync_d, r_vsync_d, r_video_on_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hsync_d    <= ~SYNC_POL;
            r_vsync_d    <= ~SYNC_POL;
            r_video_on_d <= 1'b0;
        end else if (w_p_tick) begin
            r_hsync_d    <= r_hsync;
            r_vsync_d    <= r_vsync;
            r_video_on_d <= w_video_on;
        end
    end

    assign vga.hsync    = r_hsync_d;
    assign vga.vsync    = r_vsync_d;
    assign vga.video_on = r_video_on_d;
`else
    assign vga.hsync    = r_hsync;
    assign vga.vsync    = r_vsync;
    assign vga.video_on = w_video_on;
`endif

    assign vga.p_tick     = w_p_tick;
    assign vga.pixel_x    = r_x;
    assign vga.pixel_y    = r_y;
    assign vga.frame_tick = w_p_tick && (r_x == 10'd0) && (r_y == c_v_frame);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync.sv
// ============================================================================
// Module : tb_vga_sync
// Brief  : Directed bench for vga_sync on a reduced 15x11 raster, DIV=4.
//          Expected values follow VGA_SYNC_PIPE_EN when it is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync;

    // Reduced raster: H 8+2+3+2 = 15, V 6+2+2+1 = 11.
    localparam int DIV        = 4;
    localparam int LINE_CLKS  = 15 * DIV;
    localparam int FRAME_CLKS = 15 * 11 * DIV;
`ifdef VGA_SYNC_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    vga_sync_if vga ();

    vga_sync #(
        .DIV       (DIV),
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_DISPLAY (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (1),
        .SYNC_POL  (1'b0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .vga  (vga)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_xy(input int x, input int y);
        int n = 0;
        while (!(vga.pixel_x == 10'(x) && vga.pixel_y == 10'(y)) && n < 2 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("reach_x%0d", x), 32'(vga.pixel_x), 32'(x));
    endtask

    task automatic clks_to_ptick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vga.p_tick !== 1'b1 && n < 64);
    endtask

    initial begin
        int n;
        int vs_low, vs_fall_x, vs_fall_y, ft_cnt, ft_x, ft_y, k;
        int t[3];
        logic prev_vs;

        rstn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_x",        32'(vga.pixel_x),    0);
        check("rst_y",        32'(vga.pixel_y),    0);
        check("rst_hsync",    32'(vga.hsync),      1);
        check("rst_vsync",    32'(vga.vsync),      1);
        check("rst_ptick",    32'(vga.p_tick),     0);
        check("rst_ftick",    32'(vga.frame_tick), 0);
        check("rst_video_on", 32'(vga.video_on),   32'(1 - PIPE));

        rstn = 1'b1;
        clks_to_ptick(n);
        check("first_ptick_cycle", 32'(n), 32'(DIV - 1));
        check("x_at_first_ptick",  32'(vga.pixel_x), 0);
        clks_to_ptick(n);
        check("ptick_period", 32'(n), 32'(DIV));
        check("x_second_pixel", 32'(vga.pixel_x), 1);

        // Horizontal blanking on line 0
        wait_xy(7, 0);
        check("video_on_x7", 32'(vga.video_on), 1);
        wait_xy(8, 0);
        check("video_on_x8", 32'(vga.video_on), 32'(PIPE));
        wait_xy(9, 0);
        check("video_on_x9", 32'(vga.video_on), 0);

        n = 0;
        while (vga.hsync !== 1'b0 && n < 2 * LINE_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("hsync_fall_x", 32'(vga.pixel_x), 32'(10 + PIPE));
        n = 0;
        while (vga.hsync === 1'b0 && n < 2 * LINE_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("hsync_low_clks", 32'(n), 32'(3 * DIV));
        check("hsync_rise_x", 32'(vga.pixel_x), 32'(13 + PIPE));

        // Line and frame wrap
        wait_xy(14, 3);
        clks_to_ptick(n);
        @(negedge clk);
        check("wrap_line_x", 32'(vga.pixel_x), 0);
        check("wrap_line_y", 32'(vga.pixel_y), 4);
        wait_xy(14, 10);
        clks_to_ptick(n);
        @(negedge clk);
        check("wrap_frame_x", 32'(vga.pixel_x), 0);
        check("wrap_frame_y", 32'(vga.pixel_y), 0);

        // One full frame from (0,0): vsync window and frame_tick placement
        vs_low = 0; vs_fall_x = -1; vs_fall_y = -1;
        ft_cnt = 0; ft_x = -1; ft_y = -1;
        prev_vs = vga.vsync;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            if (vga.vsync === 1'b0) begin
                vs_low++;
                if (prev_vs === 1'b1) begin
                    vs_fall_x = int'(vga.pixel_x);
                    vs_fall_y = int'(vga.pixel_y);
                end
            end
            if (vga.frame_tick === 1'b1) begin
                ft_cnt++;
                ft_x = int'(vga.pixel_x);
                ft_y = int'(vga.pixel_y);
            end
            prev_vs = vga.vsync;
            @(negedge clk);
        end
        check("vsync_low_clks", 32'(vs_low),    32'(2 * LINE_CLKS));
        check("vsync_fall_y",   32'(vs_fall_y), 8);
        check("vsync_fall_x",   32'(vs_fall_x), 32'(PIPE));
        check("ftick_per_frame", 32'(ft_cnt),   1);
        check("ftick_x",        32'(ft_x),      0);
        check("ftick_y",        32'(ft_y),      7);

        // frame_tick spacing over three frames
        t = '{0, 0, 0};
        k = 0;
        n = 0;
        while (k < 3 && n < 4 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
            if (vga.frame_tick === 1'b1) begin
                t[k] = n;
                k++;
            end
        end
        check("ftick_pulses",    32'(k),           3);
        check("ftick_interval1", 32'(t[1] - t[0]), 32'(FRAME_CLKS));
        check("ftick_interval2", 32'(t[2] - t[1]), 32'(FRAME_CLKS));

        // One-clk reset in the middle of a frame
        wait_xy(5, 4);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_x",        32'(vga.pixel_x),  0);
        check("midrst_y",        32'(vga.pixel_y),  0);
        check("midrst_ptick",    32'(vga.p_tick),   0);
        check("midrst_hsync",    32'(vga.hsync),    1);
        check("midrst_video_on", 32'(vga.video_on), 32'(1 - PIPE));
        rstn = 1'b1;
        clks_to_ptick(n);
        check("midrst_first_ptick", 32'(n), 32'(DIV - 1));
        check("midrst_x_at_ptick",  32'(vga.pixel_x), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
